// File: rtl/mips_instr_encoder.sv
// MIPS instruction encoder / program loader: packs decoded fields into R/I/J words and writes them sequentially to IMEM.
// Optional opcode filtering is enabled by defining MIPS_ENC_OPCHECK_EN.
module mips_instr_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          DEPTH     = 64
) (
    input  logic                     CLK,
    input  logic                     Reset,
    input  logic                     Start,
    input  logic                     Finish,
    input  logic                     InValid,
    output logic                     InReady,
    input  logic [5:0]               Opcode,
    input  logic [4:0]               Rs,
    input  logic [4:0]               Rt,
    input  logic [4:0]               Rd,
    input  logic [4:0]               Shamt,
    input  logic [5:0]               Funct,
    input  logic [15:0]              Imm,
    input  logic [25:0]              Target,
    output logic                     IMemWrEn,
    output logic [31:0]              IMemAddr,
    output logic [31:0]              IMemWrData,
    output logic [$clog2(DEPTH):0]   Count,
    output logic                     Full,
    output logic                     Done,
    output logic                     Error,
    output logic [5:0]               ErrOpcode
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_JUMP  = 6'b000010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state, nextState;
    logic        accept;
    logic        opSupported;
    logic        sessionStart;
    logic [31:0] encWord;

    assign Full         = (Count == CW'(DEPTH));
    assign InReady      = (state == LOAD) && !Full;
    assign accept       = InValid && InReady;
    assign Done         = (state == DONE);
    assign sessionStart = (state == IDLE) && Start;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (Reset) state <= IDLE;
        else       state <= nextState;
    end

    // NOTE: the default assigned first keeps this block free of inferred latches.
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (Start)  nextState = LOAD;
            LOAD:    if (Finish) nextState = DONE;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        encWord = {Opcode, Rs, Rt, Imm};
        if (Opcode == OP_RTYPE)     encWord = {Opcode, Rs, Rt, Rd, Shamt, Funct};
        else if (Opcode == OP_JUMP) encWord = {Opcode, Target};
    end

    // Address is taken from the pre-increment count so the first word lands on BASE_ADDR.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            IMemWrEn   <= 1'b0;
            IMemAddr   <= '0;
            IMemWrData <= '0;
            Count      <= '0;
        end else begin
            IMemWrEn <= 1'b0;
            if (sessionStart) begin
                Count <= '0;
            end else if (accept && opSupported) begin
                IMemWrEn   <= 1'b1;
                IMemAddr   <= BASE_ADDR + (32'(Count) << 2);
                IMemWrData <= encWord;
                Count      <= Count + CW'(1);
            end
        end
    end

`ifdef MIPS_ENC_OPCHECK_EN
    always_comb begin
        case (Opcode)
            6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010,
            6'b001101, 6'b001000, 6'b001001, 6'b001100, 6'b001111,
            6'b001010, 6'b001011, 6'b001110: opSupported = 1'b1;
            default:                         opSupported = 1'b0;
        endcase
    end

    // Only the first rejected opcode of a session is kept for diagnosis.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            Error     <= 1'b0;
            ErrOpcode <= '0;
        end else if (sessionStart) begin
            Error     <= 1'b0;
            ErrOpcode <= '0;
        end else if (accept && !opSupported) begin
            Error <= 1'b1;
            if (!Error) ErrOpcode <= Opcode;
        end
    end
`else
    assign opSupported = 1'b1;
    assign Error       = 1'b0;
    assign ErrOpcode   = '0;
`endif

endmodule

// File: doc/mips_instr_encoder.md
# mips_instr_encoder

Instruction encoder and program loader for the single-cycle MIPS datapath: the inverse of the opcode-to-control decode path. Accepts decoded instruction fields one per handshake, packs them into 32-bit R/I/J-format words, and writes them sequentially into instruction memory starting at a base address. Used by testbenches and the boot path to fill instruction memory before the processor is released from reset.

## Interface
- BASE_ADDR, 32'h00000000: byte address of the first word written.
- DEPTH, 64: maximum number of words per load session; power of two, 2..1024.
- CLK  in  1  clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  one-cycle pulse; begins a load session (honoured only in IDLE).
- Finish  in  1  one-cycle pulse; ends the session (honoured only in LOAD).
- InValid  in  1  field beat valid.
- InReady  out  1  encoder can accept a beat.
- Opcode  in  6  instruction opcode; selects the format.
- Rs, Rt, Rd  in  5 each  register fields.
- Shamt  in  5  shift amount.
- Funct  in  6  R-type function code.
- Imm  in  16  I-type immediate.
- Target  in  26  J-type word target.
- IMemWrEn  out  1  instruction-memory write strobe.
- IMemAddr  out  32  write byte address.
- IMemWrData  out  32  encoded word.
- Count  out  log2(DEPTH)+1  words written this session.
- Full  out  1  Count == DEPTH.
- Done  out  1  one-cycle pulse at session end.
- Error  out  1  sticky: an unsupported opcode was received this session.
- ErrOpcode  out  6  opcode of the first rejected beat.

## Operation
- States: IDLE, LOAD, DONE. Reset -> IDLE.
- IDLE: InReady=0. Start -> LOAD; Count, Error, ErrOpcode cleared to 0.
- LOAD: InReady = !Full. Accept = InValid & InReady. Finish -> DONE (beat accepted in same cycle is still processed).
- DONE: Done=1 for exactly one cycle; InReady=0; -> IDLE unconditionally.
- Format: Opcode 6'b000000 -> R: {Opcode,Rs,Rt,Rd,Shamt,Funct}. Opcode 6'b000010 -> J: {Opcode,Target}. Otherwise I: {Opcode,Rs,Rt,Imm}. Unused inputs ignored.
- Accepted, supported beat: IMemAddr = BASE_ADDR + 4*Count (pre-increment), IMemWrData = encoded word, IMemWrEn=1, Count += 1.
- Rejected beat (see Configuration): handshake completes, no write, Count unchanged, Error<=1; ErrOpcode loaded only if Error was 0.
- No wrap-around: at Full, InReady=0 and beats stall; Count saturates at DEPTH. Finish still honoured when Full.
- Start outside IDLE and Finish outside LOAD ignored.

## Timing
- Reset values: InReady=0, IMemWrEn=0, IMemAddr=0, IMemWrData=0, Count=0, Full=0, Done=0, Error=0, ErrOpcode=0, state IDLE.
- Start at edge N -> LOAD and InReady=1 in cycle N+1.
- Accept at edge N -> IMemWrEn/IMemAddr/IMemWrData/Count valid in cycle N+1 (registered, one cycle). IMemWrEn is high only for that cycle.
- Throughput: one beat per cycle while not Full. Full rises in the cycle Count reaches DEPTH; InReady falls same cycle (combinational from Full).
- Finish with accept at edge N: write and Done both in cycle N+1; Count in that cycle includes the final word.
- Reset asserted in any state, including a pending write cycle: next cycle all outputs at reset values; pending write dropped.

## Configuration
- MIPS_ENC_OPCHECK_EN defined: only opcodes 000000, 100011, 101011, 000100, 000010, 001101, 001000, 001001, 001100, 001111, 001010, 001011, 001110 are written; any other is rejected (Error path).
- Undefined: every opcode encoded per the format rule and written; Error and ErrOpcode tied to 0.

## Test plan
- Reset, Start, beat Opcode=100011 Rs=16 Rt=8 Imm=4 -> next cycle IMemWrEn=1, IMemAddr=0x0, IMemWrData=0x8E080004, Count=1.
- Back-to-back beats: add (Rs=8,Rt=9,Rd=10,Funct=0x20), j (Target=0x40), lui (Rt=1,Imm=0x1234) -> words 0x01095020, 0x08000040, 0x3C011234 at addresses 0x0, 0x4, 0x8 on consecutive cycles.
- DEPTH=4: offer 6 beats -> exactly 4 writes, Full=1, InReady=0, Count=4; Finish -> Done pulse one cycle later, state IDLE.
- MIPS_ENC_OPCHECK_EN: beats Opcode 111111 then 010000 -> no writes, Error=1, ErrOpcode=6'b111111; new Start clears Error to 0.
- Finish coincident with last accept -> write and Done in same cycle; Start during LOAD ignored (Count unchanged).
- Reset asserted during the write cycle after an accept -> following cycle IMemWrEn=0, Count=0, InReady=0, IDLE.
